// File: rtl/decode_queue.sv
// decode_queue: DEPTH-entry instruction/PC FIFO between fetch and issue.
// The head entry is decoded combinationally into register addresses,
// register-file selects, write enables, a sign-extended immediate and an
// execution-unit class. An empty queue presents all-zero decode outputs.
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int PCW   = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [PCW-1:0]           in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PCW-1:0]           out_pc,
    output logic [4:0]               rs1,
    output logic [4:0]               rs2,
    output logic [4:0]               rs3,
    output logic [4:0]               rd,
    output logic                     rs1_fp,
    output logic                     rs2_fp,
    output logic                     rd_int_we,
    output logic                     rd_fp_we,
    output logic [31:0]              imm,
    output logic [1:0]               eu_type,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [1:0] EU_BASIC   = 2'b00;
    localparam logic [1:0] EU_MULDIV  = 2'b01;
    localparam logic [1:0] EU_JMPBR   = 2'b10;
    localparam logic [1:0] EU_ILLEGAL = 2'b11;

    logic [31:0]    instr_mem [DEPTH];
    logic [PCW-1:0] pc_mem    [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [CW-1:0]  count_reg;

    logic push;
    logic pop;

    // Ready/valid come from registered occupancy only; no out_ready path.
    assign in_ready  = (count_reg != CW'(DEPTH));
    assign out_valid = (count_reg != '0);
    assign count     = count_reg;
    // A flush cycle swallows both handshakes.
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    // Entry storage: reset fills every slot with a NOP at PC 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= NOP;
                pc_mem[i]    <= '0;
            end
        end else if (push) begin
            instr_mem[wr_ptr_reg] <= in_instr;
            pc_mem[wr_ptr_reg]    <= in_pc;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            if (push && !pop)      count_reg <= count_reg + CW'(1);
            else if (pop && !push) count_reg <= count_reg - CW'(1);
        end
    end

    logic [31:0] head;
    logic [6:0]  opcode;
    logic [4:0]  f5;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign head   = instr_mem[rd_ptr_reg];
    assign opcode = head[6:0];
    assign f5     = head[31:27];
    assign imm_i  = {{20{head[31]}}, head[31:20]};
    assign imm_s  = {{20{head[31]}}, head[31:25], head[11:7]};
    assign imm_b  = {{20{head[31]}}, head[7], head[30:25], head[11:8], 1'b0};
    assign imm_u  = {head[31:12], 12'b0};
    assign imm_j  = {{12{head[31]}}, head[19:12], head[20], head[30:21], 1'b0};

    logic int_we;

    // Head-entry decode; everything is zeroed while the queue is empty.
    always_comb begin
        out_pc    = pc_mem[rd_ptr_reg];
        rd        = head[11:7];
        rs1       = head[19:15];
        rs2       = head[24:20];
        rs3       = 5'd0;
        rs1_fp    = 1'b0;
        rs2_fp    = 1'b0;
        int_we    = 1'b0;
        rd_fp_we  = 1'b0;
        imm       = 32'd0;
        eu_type   = EU_BASIC;
        rd_int_we = 1'b0;
        case (opcode)
            7'b0110111, 7'b0010111: begin imm = imm_u; int_we = 1'b1; end
            7'b1101111: begin imm = imm_j; int_we = 1'b1; eu_type = EU_JMPBR; end
            7'b1100111: begin imm = imm_i; int_we = 1'b1; eu_type = EU_JMPBR; end
            7'b1100011: begin imm = imm_b; eu_type = EU_JMPBR; end
            7'b0000011: begin imm = imm_i; int_we = 1'b1; end
            7'b0000111: begin imm = imm_i; rd_fp_we = 1'b1; end
            7'b0100011: imm = imm_s;
            7'b0100111: begin imm = imm_s; rs2_fp = 1'b1; end
            7'b0010011, 7'b0011011: begin imm = imm_i; int_we = 1'b1; end
            7'b0110011, 7'b0111011: begin
                int_we = 1'b1;
                if (head[31:25] == 7'b0000001) eu_type = EU_MULDIV;
            end
            7'b1010011: begin
                if (f5 == 5'b00010 || f5 == 5'b00011 || f5 == 5'b01011)
                    eu_type = EU_MULDIV;
                if (f5 == 5'b10100 || f5 == 5'b11000 || f5 == 5'b11100)
                    int_we = 1'b1;
                else
                    rd_fp_we = 1'b1;
                rs1_fp = !(f5 == 5'b11010 || f5 == 5'b11110);
                rs2_fp = 1'b1;
            end
            7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: begin
                rs3      = f5;
                eu_type  = EU_MULDIV;
                rs1_fp   = 1'b1;
                rs2_fp   = 1'b1;
                rd_fp_we = 1'b1;
            end
            7'b0001111, 7'b1110011: ;
            default: eu_type = EU_ILLEGAL;
        endcase
        // x0 is hardwired, so an integer write to it is dropped.
        rd_int_we = int_we && (head[11:7] != 5'd0);
        if (!out_valid) begin
            out_pc    = '0;
            rd        = 5'd0;
            rs1       = 5'd0;
            rs2       = 5'd0;
            rs3       = 5'd0;
            rs1_fp    = 1'b0;
            rs2_fp    = 1'b0;
            rd_int_we = 1'b0;
            rd_fp_we  = 1'b0;
            imm       = 32'd0;
            eu_type   = EU_BASIC;
        end
    end
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: scoreboard bench for decode_queue. Expected decode
// results are queued when a push handshake is driven and compared when the
// DUT pops the head entry.
module tb_decode_queue;
    localparam int DEPTH = 4;
    localparam int PCW   = 64;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PCW-1:0]  in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [PCW-1:0]  out_pc;
    logic [4:0]      rs1, rs2, rs3, rd;
    logic            rs1_fp, rs2_fp, rd_int_we, rd_fp_we;
    logic [31:0]     imm;
    logic [1:0]      eu_type;
    logic [2:0]      count;

    typedef struct packed {
        logic [63:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs3;
        logic [31:0] imm;
        logic [1:0]  eu;
        logic        iwe;
        logic        fwe;
        logic        r1f;
        logic        r2f;
    } exp_t;

    exp_t sb[$];
    exp_t exp_next;
    int   tests_run = 0;
    int   tests_failed = 0;

    decode_queue #(.DEPTH(DEPTH), .PCW(PCW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .rs1(rs1), .rs2(rs2), .rs3(rs3), .rd(rd),
        .rs1_fp(rs1_fp), .rs2_fp(rs2_fp), .rd_int_we(rd_int_we), .rd_fp_we(rd_fp_we),
        .imm(imm), .eu_type(eu_type), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] addi(input logic [4:0] r, input logic [11:0] k);
        return {k, 5'd0, 3'b000, r, 7'b0010011};
    endfunction

    function automatic exp_t addi_exp(input logic [4:0] r, input logic [11:0] k, input logic [63:0] pc);
        exp_t e;
        e.pc  = pc;
        e.rd  = r;
        e.rs3 = 5'd0;
        e.imm = {{20{k[11]}}, k};
        e.eu  = 2'b00;
        e.iwe = (r != 5'd0);
        e.fwe = 1'b0;
        e.r1f = 1'b0;
        e.r2f = 1'b0;
        return e;
    endfunction

    function automatic exp_t mk_exp(input logic [63:0] pc, input logic [4:0] r, input logic [4:0] r3,
                                    input logic [31:0] k, input logic [1:0] eu, input logic iwe,
                                    input logic fwe, input logic r1f, input logic r2f);
        exp_t e;
        e.pc = pc; e.rd = r; e.rs3 = r3; e.imm = k; e.eu = eu;
        e.iwe = iwe; e.fwe = fwe; e.r1f = r1f; e.r2f = r2f;
        return e;
    endfunction

    // Scoreboard: compare the popped head first, then record any new push.
    always @(negedge clk) begin
        if (!rst) begin
            if (flush) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check_eq("pop_unexpected", 64'd1, 64'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        $display("[TB] pop pc=%0h rd=%0d imm=%0h eu=%0d", out_pc, rd, imm, eu_type);
                        check_eq("pop_pc", out_pc, e.pc);
                        check_eq("pop_rd", 64'(rd), 64'(e.rd));
                        check_eq("pop_rs3", 64'(rs3), 64'(e.rs3));
                        check_eq("pop_imm", 64'(imm), 64'(e.imm));
                        check_eq("pop_eu", 64'(eu_type), 64'(e.eu));
                        check_eq("pop_int_we", 64'(rd_int_we), 64'(e.iwe));
                        check_eq("pop_fp_we", 64'(rd_fp_we), 64'(e.fwe));
                        check_eq("pop_rs1_fp", 64'(rs1_fp), 64'(e.r1f));
                        check_eq("pop_rs2_fp", 64'(rs2_fp), 64'(e.r2f));
                    end
                end
                if (in_valid && in_ready) sb.push_back(exp_next);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] ins, input logic [63:0] pc, input exp_t e);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        exp_next = e;
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 20 && count != 0; i++) step();
        out_ready = 1'b0;
        check_eq("drain_count", 64'(count), 64'd0);
        check_eq("drain_sb_left", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        out_ready = 1'b0; exp_next = '0;
        #3;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_count", 64'(count), 64'd0);
        check_eq("rst_imm", 64'(imm), 64'd0);
        check_eq("rst_eu", 64'(eu_type), 64'd0);
        check_eq("rst_out_pc", out_pc, 64'd0);
        step();
        step();
        rst = 1'b0;

        // addi x1,x0,5 at 0x100: visible one cycle after the push
        push_one(32'h0050_0093, 64'h100, addi_exp(5'd1, 12'd5, 64'h100));
        check_eq("t1_out_valid", 64'(out_valid), 64'd1);
        check_eq("t1_rd", 64'(rd), 64'd1);
        check_eq("t1_rs1", 64'(rs1), 64'd0);
        check_eq("t1_imm", 64'(imm), 64'd5);
        check_eq("t1_eu", 64'(eu_type), 64'd0);
        check_eq("t1_int_we", 64'(rd_int_we), 64'd1);
        check_eq("t1_out_pc", out_pc, 64'h100);
        drain();

        // Fill to DEPTH, refuse a fifth push, drain in order; twice for wrap
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < DEPTH; i++) begin
                logic [4:0]  r;
                logic [11:0] k;
                logic [63:0] pc;
                r  = 5'(i + 1);
                k  = 12'(16 * rep + i) - 12'd2;
                pc = 64'h200 + 64'(rep * 64) + 64'(4 * i);
                push_one(addi(r, k), pc, addi_exp(r, k, pc));
            end
            check_eq("full_count", 64'(count), 64'd4);
            check_eq("full_in_ready", 64'(in_ready), 64'd0);
            push_one(addi(5'd9, 12'd99), 64'h999, addi_exp(5'd9, 12'd99, 64'h999));
            check_eq("full_drop_count", 64'(count), 64'd4);
            drain();
        end

        // Full queue, push and pop together: push refused
        for (int i = 0; i < DEPTH; i++)
            push_one(addi(5'(i + 5), 12'hF00 + 12'(i)), 64'h300 + 64'(i),
                     addi_exp(5'(i + 5), 12'hF00 + 12'(i), 64'h300 + 64'(i)));
        in_valid = 1'b1; out_ready = 1'b1;
        in_instr = addi(5'd20, 12'd20); in_pc = 64'h3F0;
        exp_next = addi_exp(5'd20, 12'd20, 64'h3F0);
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        check_eq("fullpp_count", 64'(count), 64'd3);
        check_eq("fullpp_in_ready", 64'(in_ready), 64'd1);
        drain();

        // Half full, steady push+pop keeps occupancy at 2
        push_one(addi(5'd0, 12'd1), 64'h400, addi_exp(5'd0, 12'd1, 64'h400));
        push_one(addi(5'd2, 12'd2), 64'h404, addi_exp(5'd2, 12'd2, 64'h404));
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; out_ready = 1'b1;
            in_instr = addi(5'(i + 10), 12'(i * 3));
            in_pc    = 64'h410 + 64'(4 * i);
            exp_next = addi_exp(5'(i + 10), 12'(i * 3), 64'h410 + 64'(4 * i));
            step();
            check_eq("half_count", 64'(count), 64'd2);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        drain();

        // Decode patterns
        push_one(32'h02B5_0533, 64'h500, mk_exp(64'h500, 5'd10, 5'd0, 32'd0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0));
        check_eq("mul_eu", 64'(eu_type), 64'd1);
        push_one(32'hFE00_0EE3, 64'h504, mk_exp(64'h504, 5'd29, 5'd0, 32'hFFFF_FFFC, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0));
        push_one(32'h1005_704B, 64'h508, mk_exp(64'h508, 5'd0, 5'd2, 32'd0, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1));
        push_one(32'hFFFF_FFFF, 64'h50C, mk_exp(64'h50C, 5'd31, 5'd0, 32'd0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0));
        drain();

        // Flush with a simultaneous push: nothing survives
        for (int i = 0; i < 3; i++)
            push_one(addi(5'(i + 1), 12'd7), 64'h600 + 64'(i), addi_exp(5'(i + 1), 12'd7, 64'h600 + 64'(i)));
        flush = 1'b1; in_valid = 1'b1;
        in_instr = addi(5'd3, 12'd7); in_pc = 64'h777;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check_eq("flush_count", 64'(count), 64'd0);
        check_eq("flush_out_valid", 64'(out_valid), 64'd0);
        push_one(addi(5'd4, 12'd44), 64'h800, addi_exp(5'd4, 12'd44, 64'h800));
        check_eq("post_flush_count", 64'(count), 64'd1);
        check_eq("post_flush_pc", out_pc, 64'h800);
        drain();

        // Asynchronous reset between clock edges
        push_one(addi(5'd1, 12'd1), 64'h900, addi_exp(5'd1, 12'd1, 64'h900));
        push_one(addi(5'd2, 12'd2), 64'h904, addi_exp(5'd2, 12'd2, 64'h904));
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_out_valid", 64'(out_valid), 64'd0);
        check_eq("arst_count", 64'(count), 64'd0);
        check_eq("arst_in_ready", 64'(in_ready), 64'd1);
        sb.delete();
        step();
        rst = 1'b0;
        push_one(addi(5'd6, 12'hFFF), 64'hA00, addi_exp(5'd6, 12'hFFF, 64'hA00));
        check_eq("post_rst_pc", out_pc, 64'hA00);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised successor to the single-register decode stage of the RV64IMFD pipeline.
- Buffers fetched instructions and their PCs in a DEPTH-entry FIFO, and decodes the head entry for the execution units:
  - register addresses
  - register-file select and write enables
  - sign-extended immediate
  - EU class (basic, mul/div, jump/branch, illegal)
- Sits between fetch (stage 1) and issue/EU dispatch, with valid/ready handshakes on both sides and a flush input for redirects.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- PCW, 64, width of the PC carried alongside each instruction.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous flush; discards all queued entries.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  queue can accept an entry.
- in_instr  input  32  instruction word.
- in_pc  input  PCW  PC of in_instr.
- out_valid  output  1  head entry decoded and valid.
- out_ready  input  1  issue accepts the head entry.
- out_pc  output  PCW  PC of the head entry.
- rs1, rs2, rs3, rd  output  5 each  register addresses.
- rs1_fp, rs2_fp  output  1 each  source reads the FP register file.
- rd_int_we, rd_fp_we  output  1 each  destination write enables.
- imm  output  32  sign-extended immediate.
- eu_type  output  2  00 basic, 01 muldiv, 10 jumpbranch, 11 illegal.
- count  output  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (async, rst=1):
  - Pointers and count go to 0; every storage entry becomes instr 32'h00000013, pc 0.
  - Outputs while in reset: out_valid=0, in_ready=1, count=0, decoded fields at empty values.
- Push on in_valid && in_ready. Pop on out_valid && out_ready.
- in_ready = (count != DEPTH). It is registered-state only, with no combinational path from out_ready; a full queue refuses a push even when a pop occurs in the same cycle.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Pointers wrap modulo DEPTH.
- out_valid = (count != 0). Decode is combinational from the head entry, so latency is 1 cycle from push to out_valid.
- When empty, all decoded outputs are forced to 0 (eu_type=00, we=0, imm=0), and out_pc=0.
- Flush: next cycle count=0 and pointers=0. Any push or pop in the flush cycle is ignored. rst dominates flush.
- Decode by opcode [6:0]. rd=[11:7], rs1=[19:15], rs2=[24:20]. rs3=[31:27] for the R4 format, else 0.
  - 0110111 LUI, 0010111 AUIPC: U-format, basic, int we.
  - 1101111 JAL: J-format, jumpbranch, int we.
  - 1100111 JALR: I-format, jumpbranch, int we.
  - 1100011 BRANCH: B-format, jumpbranch, no we.
  - 0000011 LOAD: I-format, basic, int we.
  - 0000111 LOAD-FP: I-format, basic, fp we.
  - 0100011 STORE: S-format, basic.
  - 0100111 STORE-FP: S-format, basic, rs2_fp=1.
  - 0010011 / 0011011 OP-IMM(-32): I-format, basic, int we.
  - 0110011 / 0111011 OP(-32): R-format, int we; funct7=0000001 gives muldiv, else basic.
  - 1010011 OP-FP, R-format, with f5=[31:27]:
    - EU class: f5 in {00010, 00011, 01011} gives muldiv, else basic.
    - Destination: f5 in {10100, 11000, 11100} writes int, else fp.
    - Sources: rs1_fp=0 for f5 in {11010, 11110}, else 1; rs2_fp=1.
  - 1000011 / 1000111 / 1001011 / 1001111 FMADD family: R4-format, muldiv, rs1_fp=rs2_fp=1, fp we.
  - 0001111 FENCE, 1110011 SYSTEM: basic, no we.
  - Any other opcode, or instr[1:0] != 11: eu_type=11, we=0, imm=0.
- Immediates (32-bit, sign bit = instr[31]):
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - R and R4: imm=0.
- rd=0 clears rd_int_we; rd_fp_we is unaffected by rd=0.

Test Plan:
- Reset then push 0x00500093 (addi x1,x0,5) at pc 0x100 -> next cycle out_valid=1, rd=1, rs1=0, imm=5, eu_type=00, rd_int_we=1, out_pc=0x100.
- Push DEPTH=4 entries with out_ready=0 -> count=4, in_ready=0, and a 5th push is dropped. Then pop all with in_valid=0 -> the 4 entries appear in order and count returns to 0. Repeat to exercise pointer wrap.
- Queue full with push and pop in the same cycle -> push refused, count=3.
- Queue half full with push and pop each cycle -> count stays 2.
- Decode checks:
  - 0x02B50533 (mul) -> eu_type=01.
  - 0xFE000EE3 (beq, imm=-4) -> eu_type=10, imm=0xFFFFFFFC, no we.
  - 0x1005704B (FNMSUB) -> rs3=2, eu_type=01, rd_fp_we=1.
  - 0xFFFFFFFF -> eu_type=11.
- Three entries queued, flush=1 with in_valid=1 in the same cycle -> next cycle count=0 and out_valid=0; the flush-cycle instruction is not stored.
- Assert rst asynchronously mid-stream between clock edges -> out_valid=0 and count=0 immediately, in_ready=1.
